// File: rtl/data_cache_tag_controller.sv
// Data cache tag lookup/refill controller: compares stored tags against requests,
// drives block refills on misses and sweeps the whole tag array on flush.
module data_cache_tag_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 8,
    parameter int TAG_SIZE    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpu_req_i,
    input  logic [ADDR_WIDTH-1:0] cpu_address_i,
    output logic                  cpu_ready_o,
    output logic                  cpu_done_o,
    output logic                  cpu_hit_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [INDEX_BITS-1:0] tag_address_o,
    output logic                  tag_read_o,
    output logic                  tag_write_o,
    output logic [TAG_SIZE-1:0]   tag_o,
    input  logic [TAG_SIZE-1:0]   tag_i,
    output logic                  refill_req_o,
    output logic [ADDR_WIDTH-1:0] refill_address_o,
    input  logic                  refill_done_i
);
    localparam int CACHE_DEPTH = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(CACHE_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, COMPARE, REFILL, UPDATE, FLUSH} state_t;

    state_t                  state_reg, state_next;
    logic [TAG_SIZE-1:0]     req_tag_reg;
    logic [INDEX_BITS-1:0]   req_index_reg;
    logic [INDEX_BITS-1:0]   flush_cnt_reg;
    logic [CACHE_DEPTH-1:0]  valid_reg;

    logic [TAG_SIZE-1:0]     addr_tag;
    logic [INDEX_BITS-1:0]   addr_index;
    logic                    accept;
    logic                    lookup_hit;
    logic                    set_valid;
    logic                    clr_valid;
    logic                    unused_offset;

    assign addr_tag      = cpu_address_i[ADDR_WIDTH-1 -: TAG_SIZE];
    assign addr_index    = cpu_address_i[OFFSET_BITS +: INDEX_BITS];
    assign unused_offset = ^cpu_address_i[OFFSET_BITS-1:0];

    assign accept     = (state_reg == IDLE) && !flush_i && cpu_req_i;
    assign lookup_hit = valid_reg[req_index_reg] && (tag_i == req_tag_reg);
    assign set_valid  = (state_reg == UPDATE);
    assign clr_valid  = (state_reg == FLUSH);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            req_tag_reg   <= '0;
            req_index_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                req_tag_reg   <= addr_tag;
                req_index_reg <= addr_index;
            end
            if (state_reg == IDLE && flush_i)
                flush_cnt_reg <= '0;
            else if (state_reg == FLUSH)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // One flop per line; UPDATE sets the requested line, FLUSH clears the swept line.
    generate
        for (genvar gi = 0; gi < CACHE_DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk_i) begin
                if (!rst_n_i)
                    valid_reg[gi] <= 1'b0;
                else if (set_valid && req_index_reg == INDEX_BITS'(gi))
                    valid_reg[gi] <= 1'b1;
                else if (clr_valid && flush_cnt_reg == INDEX_BITS'(gi))
                    valid_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (flush_i)        state_next = FLUSH;
                else if (cpu_req_i) state_next = COMPARE;
            end
            COMPARE: state_next = lookup_hit ? IDLE : REFILL;
            REFILL:  if (refill_done_i) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            FLUSH:   if (flush_cnt_reg == LAST_INDEX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted, whatever state is registered.
    always_comb begin
        cpu_ready_o      = 1'b0;
        cpu_done_o       = 1'b0;
        cpu_hit_o        = 1'b0;
        flush_done_o     = 1'b0;
        tag_address_o    = '0;
        tag_read_o       = 1'b0;
        tag_write_o      = 1'b0;
        tag_o            = '0;
        refill_req_o     = 1'b0;
        refill_address_o = '0;
        if (rst_n_i) begin
            case (state_reg)
                IDLE: begin
                    cpu_ready_o = !flush_i;
                    if (accept) begin
                        tag_read_o    = 1'b1;
                        tag_address_o = addr_index;
                    end
                end
                COMPARE: begin
                    cpu_done_o = lookup_hit;
                    cpu_hit_o  = lookup_hit;
                end
                REFILL: begin
                    refill_req_o     = 1'b1;
                    refill_address_o = {req_tag_reg, req_index_reg, {OFFSET_BITS{1'b0}}};
                end
                UPDATE: begin
                    tag_write_o   = 1'b1;
                    tag_address_o = req_index_reg;
                    tag_o         = req_tag_reg;
                    cpu_done_o    = 1'b1;
                end
                FLUSH: begin
                    tag_write_o   = 1'b1;
                    tag_address_o = flush_cnt_reg;
                    flush_done_o  = (flush_cnt_reg == LAST_INDEX);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache_tag_controller.sv
// Directed bench for data_cache_tag_controller with a behavioural tag memory.
module tb_data_cache_tag_controller;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cpu_req_i;
    logic [31:0] cpu_address_i;
    logic        cpu_ready_o, cpu_done_o, cpu_hit_o;
    logic        flush_i, flush_done_o;
    logic [7:0]  tag_address_o;
    logic        tag_read_o, tag_write_o;
    logic [19:0] tag_o, tag_i;
    logic        refill_req_o;
    logic [31:0] refill_address_o;
    logic        refill_done_i;

    int checks = 0;
    int failures = 0;

    data_cache_tag_controller dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_req_i(cpu_req_i), .cpu_address_i(cpu_address_i),
        .cpu_ready_o(cpu_ready_o), .cpu_done_o(cpu_done_o), .cpu_hit_o(cpu_hit_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .tag_address_o(tag_address_o), .tag_read_o(tag_read_o),
        .tag_write_o(tag_write_o), .tag_o(tag_o), .tag_i(tag_i),
        .refill_req_o(refill_req_o), .refill_address_o(refill_address_o),
        .refill_done_i(refill_done_i)
    );

    always #5 clk_i = ~clk_i;

    // External tag RAM: registered read, write on the strobe.
    logic [19:0] tag_mem [256];
    initial for (int i = 0; i < 256; i++) tag_mem[i] = 20'h0;
    always @(posedge clk_i) begin
        if (tag_write_o) tag_mem[tag_address_o] <= tag_o;
        if (tag_read_o)  tag_i <= tag_mem[tag_address_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] a, input int wait_cyc,
                          input logic exp_hit, input logic [31:0] exp_ra);
        logic [7:0]  idx;
        logic [19:0] tg;
        idx = a[11:4];
        tg  = a[31:12];
        @(negedge clk_i);
        cpu_req_i = 1'b1;
        cpu_address_i = a;
        #1;
        chk("ready", 32'(cpu_ready_o), 32'd1);
        chk("rd_strobe", 32'(tag_read_o), 32'd1);
        chk("rd_index", 32'(tag_address_o), 32'(idx));
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        chk("cmp_done", 32'(cpu_done_o), 32'(exp_hit));
        chk("cmp_hit", 32'(cpu_hit_o), 32'(exp_hit));
        if (!exp_hit) begin
            @(negedge clk_i);
            chk("refill_req", 32'(refill_req_o), 32'd1);
            chk("refill_addr", refill_address_o, exp_ra);
            repeat (wait_cyc) @(negedge clk_i);
            chk("refill_held", 32'(refill_req_o), 32'd1);
            refill_done_i = 1'b1;
            @(negedge clk_i);
            refill_done_i = 1'b0;
            chk("upd_write", 32'(tag_write_o), 32'd1);
            chk("upd_read_off", 32'(tag_read_o), 32'd0);
            chk("upd_index", 32'(tag_address_o), 32'(idx));
            chk("upd_tag", 32'(tag_o), 32'(tg));
            chk("upd_done", 32'(cpu_done_o), 32'd1);
            chk("upd_hit", 32'(cpu_hit_o), 32'd0);
        end
        @(negedge clk_i);
        chk("back_idle", 32'(cpu_ready_o), 32'd1);
        chk("no_refill", 32'(refill_req_o), 32'd0);
        chk("done_pulse", 32'(cpu_done_o), 32'd0);
        $display("lookup addr=0x%08h hit_exp=%0d refill_wait=%0d", a, exp_hit, wait_cyc);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          wait_cyc;
        logic        exp_hit;
        logic [31:0] exp_ra;
    } vec_t;

    vec_t vecs [6];
    logic flush_err;
    int   write_cnt;

    initial begin
        vecs[0] = '{32'h0000_1230, 3, 1'b0, 32'h0000_1230};
        vecs[1] = '{32'h0000_123C, 0, 1'b1, 32'h0};
        vecs[2] = '{32'h0001_1234, 1, 1'b0, 32'h0001_1230};
        vecs[3] = '{32'h0000_1230, 2, 1'b0, 32'h0000_1230};
        vecs[4] = '{32'h0000_1238, 0, 1'b1, 32'h0};
        vecs[5] = '{32'hABCD_E5F4, 0, 1'b0, 32'hABCD_E5F0};

        rst_n_i = 1'b0; cpu_req_i = 1'b0; cpu_address_i = '0;
        flush_i = 1'b0; refill_done_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(cpu_ready_o), 32'd0);
        chk("rst_refill", 32'(refill_req_o), 32'd0);
        chk("rst_write", 32'(tag_write_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(cpu_ready_o), 32'd1);

        for (int i = 0; i < 6; i++)
            lookup(vecs[i].addr, vecs[i].wait_cyc, vecs[i].exp_hit, vecs[i].exp_ra);

        // Stray refill_done in IDLE must not move the FSM.
        @(negedge clk_i);
        refill_done_i = 1'b1;
        @(negedge clk_i);
        refill_done_i = 1'b0;
        chk("stray_done_ready", 32'(cpu_ready_o), 32'd1);
        chk("stray_done_write", 32'(tag_write_o), 32'd0);
        $display("stray refill_done in IDLE");

        // Flush with a colliding request: flush wins, request dropped.
        flush_i = 1'b1; cpu_req_i = 1'b1; cpu_address_i = 32'h0000_1230;
        #1;
        chk("flush_ready_low", 32'(cpu_ready_o), 32'd0);
        chk("flush_no_read", 32'(tag_read_o), 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0; cpu_req_i = 1'b0;
        flush_err = 1'b0;
        write_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (tag_write_o === 1'b1) write_cnt++;
            if (tag_address_o !== 8'(i) || tag_o !== 20'h0 || cpu_ready_o !== 1'b0 ||
                tag_read_o !== 1'b0 || flush_done_o !== (i == 255))
                flush_err = 1'b1;
            if (i != 255) @(negedge clk_i);
        end
        chk("flush_sweep_err", 32'(flush_err), 32'd0);
        chk("flush_writes", 32'(write_cnt), 32'd256);
        @(negedge clk_i);
        chk("flush_end_ready", 32'(cpu_ready_o), 32'd1);
        chk("flush_done_pulse", 32'(flush_done_o), 32'd0);
        $display("flush sweep writes=%0d", write_cnt);

        // Stored tag is 0 after flush, so a tag-0 request misses only via the valid bit.
        lookup(32'h0000_0230, 0, 1'b0, 32'h0000_0230);
        lookup(32'h0001_1230, 0, 1'b0, 32'h0001_1230);
        lookup(32'h0001_1230, 0, 1'b1, 32'h0);

        // Reset while in REFILL.
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_address_i = 32'h0002_1230;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_refill", 32'(refill_req_o), 32'd1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_refill", 32'(refill_req_o), 32'd0);
        chk("mid_rst_write", 32'(tag_write_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("after_rst_ready", 32'(cpu_ready_o), 32'd1);
        chk("after_rst_refill", 32'(refill_req_o), 32'd0);
        chk("after_rst_write", 32'(tag_write_o), 32'd0);
        $display("reset during refill");
        lookup(32'h0001_1230, 0, 1'b0, 32'h0001_1230);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_cache_tag_controller.md
# data_cache_tag_controller

Lookup and refill controller for the data cache tag array. Accepts load/store lookup requests from the memory stage, reads the data tag memory through its read/write port, compares the stored tag and a private valid bit against the request, and reports hit/miss. On a miss it requests a block refill from the memory interface, then writes the new tag and sets the valid bit. It also performs a full-cache invalidate sweep on request.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- OFFSET_BITS, 4, block offset bits (16-byte block)
- INDEX_BITS, 8, index bits; CACHE_DEPTH = 2^INDEX_BITS = 256
- TAG_SIZE, ADDR_WIDTH-INDEX_BITS-OFFSET_BITS = 20

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- cpu_req_i  in  1  lookup request; accepted when cpu_ready_o=1
- cpu_address_i  in  ADDR_WIDTH  request address: tag [31:12], index [11:4], offset [3:0]
- cpu_ready_o  out  1  controller can accept a request this cycle
- cpu_done_o  out  1  one-cycle pulse: lookup complete
- cpu_hit_o  out  1  valid with cpu_done_o: 1 hit, 0 miss (refilled)
- flush_i  in  1  invalidate-all request, sampled in IDLE
- flush_done_o  out  1  one-cycle pulse at end of sweep
- tag_address_o  out  INDEX_BITS  tag memory index
- tag_read_o  out  1  tag memory read strobe
- tag_write_o  out  1  tag memory write strobe
- tag_o  out  TAG_SIZE  tag to write
- tag_i  in  TAG_SIZE  tag read data, valid one cycle after tag_read_o
- refill_req_o  out  1  block refill request, level, held until refill_done_i
- refill_address_o  out  ADDR_WIDTH  block-aligned refill address (offset bits zero)
- refill_done_i  in  1  refill complete, one-cycle pulse

## Operation
- Internal valid array, CACHE_DEPTH bits, flops; cleared by reset and flush.
- Request register latches tag and index on acceptance.
- FSM states: IDLE, COMPARE, REFILL, UPDATE, FLUSH.
- IDLE: cpu_ready_o = !flush_i. If flush_i: counter<=0, go FLUSH (flush has priority; simultaneous cpu_req_i is not accepted). Else if cpu_req_i: latch address, tag_read_o=1, tag_address_o=index, go COMPARE.
- COMPARE: hit = valid[index] && (tag_i == latched tag). Hit: cpu_done_o=1, cpu_hit_o=1, go IDLE. Miss: go REFILL.
- REFILL: refill_req_o=1, refill_address_o={tag,index,0000}. On refill_done_i go UPDATE.
- UPDATE: tag_write_o=1, tag_address_o=index, tag_o=latched tag, valid[index]<=1, cpu_done_o=1, cpu_hit_o=0, go IDLE.
- FLUSH: each cycle tag_write_o=1, tag_address_o=counter, tag_o=0, valid[counter]<=0, counter+1. When counter=CACHE_DEPTH-1: flush_done_o=1, go IDLE. Counter is INDEX_BITS wide; wrap to 0 is never used.
- tag_read_o and tag_write_o never asserted together.

## Timing
- Reset: state IDLE, valid array all 0, counter 0; every output 0 (cpu_ready_o becomes 1 the first cycle after reset deasserts, combinationally from IDLE).
- Hit latency: request accepted at edge N, cpu_done_o high in cycle N+1.
- Miss: refill_req_o high from cycle N+1 (COMPARE decides) -> asserted cycle N+2 onward; refill_done_i sampled high at cycle M -> UPDATE in M+1 with cpu_done_o; IDLE at M+2.
- refill_done_i in the first REFILL cycle is accepted.
- refill_done_i outside REFILL is ignored.
- Back-to-back same index after UPDATE: new tag visible to next lookup (write completes at UPDATE edge).
- Flush: CACHE_DEPTH cycles in FLUSH, flush_done_o on the last; cpu_ready_o=0 throughout.
- Reset mid-REFILL/FLUSH: next cycle IDLE, refill_req_o=0, no tag write, all valid bits 0.

## Test plan
- Reset, lookup 0x0000_1230 (index 0x23, tag 0x00001) -> COMPARE miss; refill_req_o=1, refill_address_o=0x0000_1230; refill_done_i after 3 cycles -> next cycle tag_write_o=1, tag_address_o=0x23, tag_o=0x00001, cpu_done_o=1, cpu_hit_o=0.
- Repeat lookup 0x0000_123C -> cpu_done_o=1, cpu_hit_o=1 one cycle after acceptance, no refill_req_o.
- Lookup 0x0001_1234 (same index, tag 0x00011) -> miss, refill_address_o=0x0001_1230, tag overwritten; then 0x0000_1230 -> miss.
- flush_i and cpu_req_i same cycle in IDLE -> request not accepted; 256 writes with tag_address_o 0x00..0xFF, tag_o=0; flush_done_o with index 0xFF; then lookup 0x0001_1230 -> miss.
- refill_done_i asserted in first cycle of refill_req_o -> UPDATE next cycle, total miss latency 3 cycles.
- rst_n_i low during REFILL -> refill_req_o 0 next cycle, no tag_write_o, subsequent lookup of previously valid line misses.
